// File: rtl/f_fetch_pc_unit.sv
// ---------------------------------------------------------------------------
// f_fetch_pc_unit
//   F-stage program counter. Produces the fetch PC (sequential PC+4) and
//   accepts redirects from D (branch/jump) and from CP0 (exception, ERET).
//   CP0 redirects override stalls. A D-stage redirect that arrives while
//   fetch is stalled is buffered (HOLD) and applied on the first enabled
//   edge. Fetch address errors are flagged for the exception path.
//
// Ports
//   clk           in   rising-edge clock
//   reset         in   synchronous, active-high
//   en            in   fetch advance enable (0 = stall)
//   br_valid      in   D-stage redirect request
//   br_target     in   D-stage redirect target
//   exc_req       in   exception taken -> EXC_VECTOR
//   eret_req      in   ERET executed   -> epc
//   epc           in   return PC from CP0
//   pc            out  current fetch PC (registered)
//   pc_err        out  pc misaligned or outside instruction memory
//   exc_code      out  5'd4 (AdEL) when pc_err, else 0
//   redir_pending out  a D-stage redirect is buffered
//   im_addr       out  instruction memory word index, valid when !pc_err
// ---------------------------------------------------------------------------
module f_fetch_pc_unit #(
  parameter int unsigned          ADDR_W     = 32,
  parameter logic [ADDR_W-1:0]    PC_BASE    = 32'h0000_3000,
  parameter int unsigned          IM_WORDS   = 4096,
  parameter logic [ADDR_W-1:0]    EXC_VECTOR = 32'h0000_4180
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        en,
  input  logic                        br_valid,
  input  logic [ADDR_W-1:0]           br_target,
  input  logic                        exc_req,
  input  logic                        eret_req,
  input  logic [ADDR_W-1:0]           epc,
  output logic [ADDR_W-1:0]           pc,
  output logic                        pc_err,
  output logic [4:0]                  exc_code,
  output logic                        redir_pending,
  output logic [$clog2(IM_WORDS)-1:0] im_addr
);

  localparam int unsigned IM_AW = $clog2(IM_WORDS);

  // Highest legal word-aligned fetch address.
  localparam logic [ADDR_W-1:0] PC_LAST =
    ADDR_W'(PC_BASE + ADDR_W'(4 * IM_WORDS) - ADDR_W'(4));

  localparam logic [4:0] EXC_ADEL = 5'd4;

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  logic [ADDR_W-1:0] pc_p0;
  logic [ADDR_W-1:0] pend_tgt_p0;
  logic [0:0]        state_p0;

  // Full-width range compare so wrapped or far-away addresses are caught.
  function automatic logic addr_err(input logic [ADDR_W-1:0] a);
    addr_err = (a[1:0] != 2'b00) || (a < PC_BASE) || (a > PC_LAST);
  endfunction

  // Stage p0: fetch PC register and redirect buffer
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_p0       <= PC_BASE;
      pend_tgt_p0 <= '0;
      state_p0    <= ST_RUN;
    end else if (exc_req) begin
      pc_p0    <= EXC_VECTOR;
      state_p0 <= ST_RUN;
    end else if (eret_req) begin
      pc_p0    <= epc;
      state_p0 <= ST_RUN;
    end else if (!en) begin
      // Stalled: remember the newest D-stage redirect for later.
      if (br_valid) begin
        pend_tgt_p0 <= br_target;
        state_p0    <= ST_HOLD;
      end
    end else if (br_valid) begin
      // A live redirect supersedes anything buffered.
      pc_p0    <= br_target;
      state_p0 <= ST_RUN;
    end else if (state_p0 == ST_HOLD) begin
      pc_p0    <= pend_tgt_p0;
      state_p0 <= ST_RUN;
    end else begin
      pc_p0 <= pc_p0 + ADDR_W'(4);
    end
  end

  assign pc            = pc_p0;
  assign redir_pending = (state_p0 == ST_HOLD);
  assign pc_err        = addr_err(pc_p0);
  assign exc_code      = pc_err ? EXC_ADEL : 5'd0;

  // PC_BASE is word aligned, so the word offset needs only pc[IM_AW+1:2].
  assign im_addr = pc_p0[IM_AW+1:2] - PC_BASE[IM_AW+1:2];

endmodule

// File: tb/tb_f_fetch_pc_unit.sv
module tb_f_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        reset, en, br_valid, exc_req, eret_req;
  logic [31:0] br_target, epc;
  logic [31:0] pc;
  logic        pc_err, redir_pending;
  logic [4:0]  exc_code;
  logic [11:0] im_addr;

  f_fetch_pc_unit dut (
    .clk(clk), .reset(reset), .en(en), .br_valid(br_valid),
    .br_target(br_target), .exc_req(exc_req), .eret_req(eret_req),
    .epc(epc), .pc(pc), .pc_err(pc_err), .exc_code(exc_code),
    .redir_pending(redir_pending), .im_addr(im_addr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic        err;
    logic [4:0]  code;
    logic        pend;
    logic        chk_im;
    logic [11:0] im;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    tests = 0;
  int    fails = 0;

  // Monitor: every edge the DUT presents a new PC; compare it with the
  // oldest outstanding expectation.
  always @(posedge clk) begin
    #1;
    while (exp_q.size() > 0) begin
      exp_t  e;
      string n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      tests++;
      if (pc !== e.pc || pc_err !== e.err || exc_code !== e.code ||
          redir_pending !== e.pend || (e.chk_im && im_addr !== e.im)) begin
        fails++;
        $display("FAIL %s: got pc=%h err=%b code=%0d pend=%b im=%h, want pc=%h err=%b code=%0d pend=%b im=%h",
                 n, pc, pc_err, exc_code, redir_pending, im_addr,
                 e.pc, e.err, e.code, e.pend, e.im);
      end
    end
  end

  task automatic step(input string n, input logic r, input logic e,
                      input logic b, input logic [31:0] t,
                      input logic x, input logic er, input logic [31:0] ep,
                      input logic [31:0] xpc, input logic xerr,
                      input logic xpend, input logic xchk,
                      input logic [11:0] xim);
    exp_t ex;
    @(negedge clk);
    reset = r; en = e; br_valid = b; br_target = t;
    exc_req = x; eret_req = er; epc = ep;
    @(posedge clk);
    ex.pc = xpc; ex.err = xerr; ex.code = xerr ? 5'd4 : 5'd0;
    ex.pend = xpend; ex.chk_im = xchk; ex.im = xim;
    exp_q.push_back(ex);
    name_q.push_back(n);
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; br_valid = 1'b0; br_target = '0;
    exc_req = 1'b0; eret_req = 1'b0; epc = '0;
    //    name          rst en br target        exc eret epc           pc            err pend chk im
    step("reset",        1, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3000, 0, 0, 1, 12'h000);
    step("seq1",         0, 1, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3004, 0, 0, 1, 12'h001);
    step("seq2",         0, 1, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3008, 0, 0, 1, 12'h002);
    step("seq3",         0, 1, 0, 32'h0,        0, 0, 32'h0,        32'h0000_300C, 0, 0, 1, 12'h003);
    step("branch",       0, 1, 1, 32'h3100,     0, 0, 32'h0,        32'h0000_3100, 0, 0, 1, 12'h040);
    step("after_br",     0, 1, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3104, 0, 0, 1, 12'h041);
    step("stall_br",     0, 0, 1, 32'h3200,     0, 0, 32'h0,        32'h0000_3104, 0, 1, 1, 12'h041);
    step("stall2",       0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3104, 0, 1, 1, 12'h041);
    step("stall3",       0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3104, 0, 1, 1, 12'h041);
    step("hold_apply",   0, 1, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3200, 0, 0, 1, 12'h080);
    step("hold_a",       0, 0, 1, 32'h3300,     0, 0, 32'h0,        32'h0000_3200, 0, 1, 1, 12'h080);
    step("hold_overwr",  0, 0, 1, 32'h3340,     0, 0, 32'h0,        32'h0000_3200, 0, 1, 1, 12'h080);
    step("live_wins",    0, 1, 1, 32'h3400,     0, 0, 32'h0,        32'h0000_3400, 0, 0, 1, 12'h100);
    step("hold_b",       0, 0, 1, 32'h3500,     0, 0, 32'h0,        32'h0000_3400, 0, 1, 1, 12'h100);
    step("exc_in_hold",  0, 0, 0, 32'h0,        1, 0, 32'h0,        32'h0000_4180, 0, 0, 1, 12'h460);
    step("eret",         0, 0, 0, 32'h0,        0, 1, 32'h3010,     32'h0000_3010, 0, 0, 1, 12'h004);
    step("exc_and_eret", 0, 0, 0, 32'h0,        1, 1, 32'h3020,     32'h0000_4180, 0, 0, 1, 12'h460);
    step("misalign",     0, 1, 1, 32'h3002,     0, 0, 32'h0,        32'h0000_3002, 1, 0, 0, 12'h000);
    step("misalign_seq", 0, 1, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3006, 1, 0, 0, 12'h000);
    step("below_base",   0, 1, 1, 32'h2FFC,     0, 0, 32'h0,        32'h0000_2FFC, 1, 0, 0, 12'h000);
    step("last_word",    0, 1, 1, 32'h6FFC,     0, 0, 32'h0,        32'h0000_6FFC, 0, 0, 1, 12'hFFF);
    step("past_end",     0, 1, 0, 32'h0,        0, 0, 32'h0,        32'h0000_7000, 1, 0, 0, 12'h000);
    step("eret_en",      0, 1, 0, 32'h0,        0, 1, 32'h3010,     32'h0000_3010, 0, 0, 1, 12'h004);
    step("top_addr",     0, 1, 1, 32'hFFFF_FFFC, 0, 0, 32'h0,       32'hFFFF_FFFC, 1, 0, 0, 12'h000);
    step("wrap",         0, 1, 0, 32'h0,        0, 0, 32'h0,        32'h0000_0000, 1, 0, 0, 12'h000);
    step("eret_back",    0, 0, 0, 32'h0,        0, 1, 32'h3008,     32'h0000_3008, 0, 0, 1, 12'h002);
    step("hold_c",       0, 0, 1, 32'h3600,     0, 0, 32'h0,        32'h0000_3008, 0, 1, 1, 12'h002);
    step("reset_hold",   1, 0, 1, 32'h3700,     1, 0, 32'h0,        32'h0000_3000, 0, 0, 1, 12'h000);
    step("post_reset",   0, 1, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3004, 0, 0, 1, 12'h001);

    // Let the monitor drain, with a bound in case it never does.
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/f_fetch_pc_unit.md
Name: f_fetch_pc_unit

Overview:
- Parametrised successor of the F-stage PC register.
- Generates the fetch PC internally (sequential PC+4), accepts branch/jump redirects from D, and takes exception/ERET redirects from the CP0 stage with priority over pipeline stalls.
- Buffers a redirect that arrives while fetch is stalled, and flags fetch address errors (misaligned or outside instruction memory) for the exception path.
- Sits between the D-stage NPC logic and the instruction memory address port.

Parameters:
- ADDR_W, 32, PC/address width in bits.
- PC_BASE, 32'h0000_3000, reset PC and lowest legal IM address.
- IM_WORDS, 4096, instruction memory depth in 32-bit words; legal range is PC_BASE .. PC_BASE+4*IM_WORDS-4.
- EXC_VECTOR, 32'h0000_4180, exception handler entry PC.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- en  in  1  fetch advance enable; 0 = stall (hazard unit).
- br_valid  in  1  D-stage redirect request this cycle.
- br_target  in  ADDR_W  redirect target PC.
- exc_req  in  1  exception taken; redirect to EXC_VECTOR.
- eret_req  in  1  ERET executed; redirect to epc.
- epc  in  ADDR_W  return PC from CP0.
- pc  out  ADDR_W  current fetch PC (registered).
- pc_err  out  1  combinational: pc misaligned (pc[1:0]!=0) or out of IM range.
- exc_code  out  5  5'd4 (AdEL) when pc_err=1, else 5'd0.
- redir_pending  out  1  a redirect is buffered in HOLD.
- im_addr  out  $clog2(IM_WORDS)  word index (pc-PC_BASE)>>2, truncated.

Behaviour:
- Reset: pc<=PC_BASE, state<=RUN, pending target<=0, redir_pending=0. Reset has priority over every other input.
- Two states: RUN (no buffered redirect) and HOLD (redirect buffered, value in pend_tgt).
- Next-PC priority at each rising edge, highest first:
  - reset.
  - exc_req: pc<=EXC_VECTOR. Ignores en, clears any pending redirect, state->RUN.
  - eret_req: pc<=epc. Ignores en, clears pending, state->RUN.
  - en=0: pc held. If br_valid=1, then pend_tgt<=br_target and state->HOLD; a later br_valid while in HOLD overwrites pend_tgt.
  - en=1 and br_valid=1: pc<=br_target, state->RUN. A live request wins over a buffered one.
  - en=1 and state=HOLD: pc<=pend_tgt, state->RUN.
  - en=1 otherwise: pc<=pc+4. Modulo 2^ADDR_W; wrap is not trapped here, and pc_err flags the out-of-range result.
- exc_req and eret_req asserted together: exc_req wins.
- Redirect latency: 1 cycle. Target is visible on pc the edge after the request is sampled with en=1. If en=0 at request time, the target appears on the first edge with en=1.
- pc_err and exc_code are purely combinational from pc, with no added latency. The unit keeps fetching from an erroneous PC; the exception stage is responsible for raising exc_req.
- Range check uses full ADDR_W comparison. A PC of PC_BASE-4 or PC_BASE+4*IM_WORDS is an error.
- im_addr is valid only when pc_err=0.
- Reset mid-HOLD discards the buffered redirect.

Test Plan:
- Reset, then en=1 for 3 cycles -> pc = 0x3000, 0x3004, 0x3008, 0x300C; pc_err=0 throughout.
- en=1, br_valid=1, br_target=0x3100 for 1 cycle -> next pc=0x3100, then 0x3104.
- en=0, br_valid=1, target 0x3200 pulsed for 1 cycle, en held 0 for 3 cycles -> pc held and redir_pending=1. Then en=1 -> pc=0x3200, redir_pending=0.
- While in HOLD with en=0: exc_req=1 -> pc=0x4180, redir_pending=0. Next cycle: eret_req=1, epc=0x3010 -> pc=0x3010. exc_req and eret_req together -> pc=0x4180.
- br_target=0x3002 -> pc_err=1, exc_code=4. Target 0x2FFC -> pc_err=1. Target 0x6FFC with IM_WORDS=4096 -> pc_err=0; the following fetch at 0x7000 -> pc_err=1.
- Reset asserted together with exc_req, br_valid, and en=0 in HOLD -> pc=0x3000, state RUN, redir_pending=0.
